serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//  Bit-serial ripple-borrow subtractor: d = a - b - bin over W bits, one bit per clock.
//  Inverse companion of the combinational ripple-carry adders.
//  Trades latency for area: one full-subtractor cell plus shift registers instead of W cells.
//  Sits behind a valid/ready handshake on both input and result sides.
// PARAMETERS
//  W   8   operand/result width in bits; legal range W >= 1
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   operands a, b, bin valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   W   minuend
//  b          in   W   subtrahend
//  bin        in   1   borrow in
//  out_valid  out  1   result d/bout valid
//  out_ready  in   1   consumer accepts result
//  d          out  W   difference, a - b - bin mod 2^W
//  bout       out  1   borrow out (1 when a < b + bin, unsigned)
//  ovf        out  1   signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  - Single clock domain; rst is synchronous and active-high.
//  - Reset: state=IDLE, out_valid=0, d=0, bout=0, ovf=0, bit counter=0, in_ready=1 from first post-reset cycle.
//  - in_ready = (state==IDLE); combinational decode of state only.
//  - FSM states IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: on in_valid&&in_ready edge, load a, b into shift regs, borrow reg <= bin, cnt <= 0, go BUSY.
//  - BUSY: each edge processes LSB: di = ai^bi^br; br' = (~ai&bi) | (~(ai^bi)&br).
//    Shift a, b right; shift di into result MSB; cnt++.
//    On the edge where cnt reaches W-1: result and bout registered, go DONE.
//  - Latency: out_valid rises exactly W clock edges after the accepting edge.
//  - DONE: out_valid=1; d, bout, ovf held stable until out_valid&&out_ready edge, then IDLE.
//  - Throughput: at most one op per W+2 cycles (IDLE accept, W BUSY, >=1 DONE); no overlap.
//  - in_valid while in_ready=0 ignored, no effect on state or outputs.
//  - out_ready while out_valid=0 ignored.
//  - Counter width $clog2(W+1); W=1 is legal (one BUSY cycle).
//  - d/bout are registered; not valid (value unspecified beyond reset value) unless out_valid=1.
//  - rst mid-operation (BUSY or DONE): op aborted, result discarded, reset values next cycle.
//  - rst has priority over all handshake events in the same cycle.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: port ovf present; registered with d in DONE.
//    ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), using the captured operand MSBs.
//    bin is included in d; ovf is defined by this formula only.
//  SERIAL_SUB_OVF_EN undefined: no ovf port, no MSB capture logic; all other behaviour identical.
// TESTING (W=8)
//  1. a=0x5A b=0x3C bin=0 -> d=0x1E bout=0; out_valid exactly 8 edges after accept.
//  2. a=0x00 b=0x01 bin=0 -> d=0xFF bout=1.
//  3. SERIAL_SUB_OVF_EN on, a=0x80 b=0x01 bin=0 -> d=0x7F bout=0 ovf=1; a=0x05 b=0x03 -> ovf=0.
//  4. a=0x10 b=0x10 bin=1 -> d=0xFF bout=1.
//  5. out_ready=0 for 5 cycles in DONE, in_valid pulsed -> d/bout stable, in_ready=0, no new accept.
//     out_ready=1 -> IDLE next cycle, in_ready=1.
//  6. rst at 3rd BUSY cycle -> next cycle out_valid=0 d=0 in_ready=1.
//     Then a=0xFF b=0xFF bin=1 -> d=0xFF bout=1.

Source files
------------

// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result valid-ready bundle for serial_sub (ovf only with SERIAL_SUB_OVF_EN)
interface serial_sub_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , ovf
`endif
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple-borrow subtractor d = a - b - bin; SERIAL_SUB_OVF_EN adds signed overflow flag
module serial_sub #(parameter int W = 8) (
  input logic        clk,
  input logic        rst,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;
  st_t          st, st_n;
  logic [W-1:0] as, bs, r;
  logic [CW-1:0] cnt;
  logic         br, last, ai, bi, di, brn;
`ifdef SERIAL_SUB_OVF_EN
  logic         am, bm, ovf_q;
`endif
  always_ff @(posedge clk) st <= rst ? IDLE : st_n;
  always_comb begin
    st_n = st == IDLE ? (bus.in_valid ? BUSY : IDLE) :
           st == BUSY ? (last ? DONE : BUSY) :
           st == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  always_comb begin
    bus.in_ready  = st == IDLE;
    bus.out_valid = st == DONE;
  end
  assign last = cnt == CW'(W - 1);
  assign ai   = as[0];
  assign bi   = bs[0];
  assign di   = ai ^ bi ^ br;
  assign brn  = (~ai & bi) | (~(ai ^ bi) & br);
  // the result fills from the MSB end so it is aligned once W bits have shifted in
  always_ff @(posedge clk) begin
    if (rst) begin
      as  <= '0;
      bs  <= '0;
      r   <= '0;
      br  <= 1'b0;
      cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
      am    <= 1'b0;
      bm    <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else if (st == IDLE && bus.in_valid) begin
      as  <= bus.a;
      bs  <= bus.b;
      br  <= bus.bin;
      cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
      am <= bus.a[W-1];
      bm <= bus.b[W-1];
`endif
    end else if (st == BUSY) begin
      as  <= as >> 1;
      bs  <= bs >> 1;
      r   <= W'({di, r} >> 1);
      br  <= brn;
      cnt <= cnt + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
      if (last) ovf_q <= (am ^ bm) & (di ^ am);
`endif
    end
  end
  assign bus.d    = r;
  assign bus.bout = br;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: vector table, corner sequences and random ops against an arithmetic model
module tb_serial_sub;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  serial_sub_if #(.W(W)) bus ();
  serial_sub #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_out(input logic [W-1:0] ed, input logic eb, input logic eo);
    chk("d", bus.d, ed);
    chk("bout", bus.bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", bus.ovf, eo);
`else
    if (eo === 1'bx) chk("ovf_model", 0, 1);
`endif
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input int hold, input bit pulse);
    int n;
    chk("in_ready_idle", bus.in_ready, 1);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_busy", bus.in_ready, 0);
    n = 0;
    while (!bus.out_valid && n < 4 * W + 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, W);
    check_out(ed, eb, eo);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.in_valid = 1'b1;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      check_out(ed, eb, eo);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int x;
    logic [W-1:0] dd;
    x  = int'(a) - int'(b) - int'(bin);
    dd = W'(x);
    return {dd, x < 0, (a[W-1] != b[W-1]) && (dd[W-1] != a[W-1])};
  endfunction
  initial begin
    logic [W-1:0] ra, rb, md;
    logic rbin, mb, mo;
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[4] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    check_out('0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("idle_out_ready_valid", bus.out_valid, 0);
    chk("idle_out_ready_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 6; i++)
      run_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bout, vt[i].ovf, 1, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 5, 1'b1);
    @(posedge clk); #1;
    chk("no_accept_in_ready", bus.in_ready, 1);
    chk("no_accept_valid", bus.out_valid, 0);
    bus.a = 8'h5A;
    bus.b = 8'h3C;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    check_out('0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      if (i == 0) begin ra = '0; rb = '1; rbin = 1'b1; end
      if (i == 1) begin ra = '1; rb = '0; rbin = 1'b0; end
      {md, mb, mo} = model(ra, rb, rbin);
      run_op(ra, rb, rbin, md, mb, mo, int'($urandom_range(0, 3)), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
